// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port among three requesters:
//   the writeback stage (wb, absolute priority), the JAL link writer (link,
//   always writes $ra) and the syscall unit (sys). link and sys alternate
//   round-robin when both are eligible in the same cycle. A starvation
//   counter raises stall_req so the pipeline drains and link/sys get served.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   wb_valid/wb_reg/wb_data  writeback request (never refused)
//   link_valid/link_addr     JAL link request, pushed into a small FIFO
//   link_ready               FIFO not full (push = link_valid & link_ready)
//   sys_valid/sys_reg/...    syscall request, held until sys_ready
//   sys_ready                combinational: sys consumed this cycle
//   wr_en/wr_reg/wr_data     registered register file write port
//   stall_req                registered: ask hazard unit to hold writeback
//   link_count               link FIFO occupancy
module regfile_write_arbiter #(
    parameter int LINK_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_reg,
    input  logic [31:0]                   wb_data,
    input  logic                          link_valid,
    input  logic [31:0]                   link_addr,
    output logic                          link_ready,
    input  logic                          sys_valid,
    input  logic [4:0]                    sys_reg,
    input  logic [31:0]                   sys_data,
    output logic                          sys_ready,
    output logic                          wr_en,
    output logic [4:0]                    wr_reg,
    output logic [31:0]                   wr_data,
    output logic                          stall_req,
    output logic [$clog2(LINK_DEPTH):0]   link_count
);

    localparam int         PW     = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;
    localparam int         CW     = $clog2(LINK_DEPTH) + 1;
    localparam int         WW     = $clog2(MAX_WAIT + 1);
    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALL
    } state_t;

    typedef enum logic {
        RR_LINK,
        RR_SYS
    } rr_t;

    // ------------------------------------------------------------------
    // Link FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [31:0]   fifo_mem [LINK_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic   push;
    logic   pop;
    state_t state;
    rr_t    rr;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_next;

    logic wb_grant;
    logic link_elig;
    logic sys_elig;
    logic link_grant;
    logic sys_grant;
    logic contention;
    logic lost;
    logic served;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    // NOTE: every output of an always_comb gets a default first so that no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        wb_grant   = wb_valid && (wb_reg != 5'd0);
        link_elig  = (count != '0);
        sys_elig   = sys_valid && (sys_reg != 5'd0);
        link_grant = 1'b0;
        sys_grant  = 1'b0;
        if (!wb_grant) begin
            if (link_elig && sys_elig) begin
                link_grant = (rr == RR_LINK);
                sys_grant  = (rr == RR_SYS);
            end else begin
                link_grant = link_elig;
                sys_grant  = sys_elig;
            end
        end
    end

    assign contention = !wb_grant && link_elig && sys_elig;
    assign served     = link_grant || sys_grant;
    assign lost       = (link_elig || sys_elig) && wb_grant;
    assign wait_next  = wait_cnt + WW'(1);

    // A $zero-targeted syscall is acknowledged without using the port.
    assign sys_ready  = sys_grant || (sys_valid && (sys_reg == 5'd0));

    // Full-only ready: a same-cycle pop does not make room for a push.
    assign link_ready = (count != CW'(LINK_DEPTH));
    assign link_count = count;
    assign push       = link_valid && link_ready;
    assign pop        = link_grant;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; clearing the
    // pointers and count already discards its contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= link_addr;
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: flips only when link and sys actually contend
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= RR_LINK;
        end else if (contention) begin
            rr <= (rr == RR_LINK) ? RR_SYS : RR_LINK;
        end
    end

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= wb_grant || served;
            if (wb_grant) begin
                wr_reg  <= wb_reg;
                wr_data <= wb_data;
            end else if (link_grant) begin
                wr_reg  <= REG_RA;
                wr_data <= fifo_mem[rd_ptr];
            end else if (sys_grant) begin
                wr_reg  <= sys_reg;
                wr_data <= sys_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation FSM: counts cycles a pending link/sys loses to wb
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            stall_req <= 1'b0;
        end else begin
            case (state)
                IDLE, WAIT: begin
                    if (served || !lost) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        // wait_cnt is 0 in IDLE, so the first loss counts as 1.
                        wait_cnt <= wait_next;
                        if (wait_next >= WW'(MAX_WAIT)) begin
                            state     <= STALL;
                            stall_req <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                STALL: begin
                    if (served) begin
                        state     <= IDLE;
                        wait_cnt  <= '0;
                        stall_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    wait_cnt  <= '0;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;
    localparam int MAXW  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        link_valid;
    logic [31:0] link_addr;
    logic        link_ready;
    logic        sys_valid;
    logic [4:0]  sys_reg;
    logic [31:0] sys_data;
    logic        sys_ready;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        stall_req;
    logic [1:0]  link_count;

    regfile_write_arbiter #(.LINK_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .link_valid(link_valid), .link_addr(link_addr), .link_ready(link_ready),
        .sys_valid(sys_valid), .sys_reg(sys_reg), .sys_data(sys_data),
        .sys_ready(sys_ready),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .stall_req(stall_req), .link_count(link_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: link FIFO as a queue, rr as a flag, starvation as a
    // count of consecutive lost cycles.
    // ------------------------------------------------------------------
    typedef struct {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_fifo[$];
    bit          m_rr_link;
    int          m_lost;
    bit          m_stall;
    logic [4:0]  m_wr_reg;
    logic [31:0] m_wr_data;
    bit          m_sys_ready;

    task automatic model_reset();
        exp_q.delete();
        m_fifo.delete();
        m_rr_link   = 1'b1;
        m_lost      = 0;
        m_stall     = 1'b0;
        m_wr_reg    = '0;
        m_wr_data   = '0;
        m_sys_ready = 1'b0;
    endtask

    // Evaluates one cycle from the current inputs; checks the combinational
    // and status outputs now and queues the write expected next cycle.
    task automatic model_step();
        bit   wbg, le, se, sz, lg, sg, push;
        exp_t e;
        wbg = wb_valid && (wb_reg != 0);
        le  = (m_fifo.size() != 0);
        se  = sys_valid && (sys_reg != 0);
        sz  = sys_valid && (sys_reg == 0);
        lg  = 1'b0;
        sg  = 1'b0;
        if (!wbg) begin
            if (le && se) begin
                if (m_rr_link) lg = 1'b1; else sg = 1'b1;
                m_rr_link = !m_rr_link;
            end else if (le) begin
                lg = 1'b1;
            end else if (se) begin
                sg = 1'b1;
            end
        end

        check("sys_ready",  sys_ready,  sg || sz);
        check("link_ready", link_ready, m_fifo.size() < DEPTH);
        check("link_count", link_count, m_fifo.size());
        check("stall_req",  stall_req,  m_stall);

        push = link_valid && (m_fifo.size() < DEPTH);
        if (wbg) begin
            m_wr_reg = wb_reg; m_wr_data = wb_data;
        end else if (lg) begin
            m_wr_reg = 5'd31; m_wr_data = m_fifo.pop_front();
        end else if (sg) begin
            m_wr_reg = sys_reg; m_wr_data = sys_data;
        end
        if (push) m_fifo.push_back(link_addr);
        e.en = wbg || lg || sg; e.rg = m_wr_reg; e.data = m_wr_data;
        exp_q.push_back(e);

        if (lg || sg) begin
            m_lost  = 0;
            m_stall = 1'b0;
        end else if ((le || se) && wbg) begin
            m_lost++;
            if (m_lost >= MAXW) m_stall = 1'b1;
        end else begin
            m_lost = 0;
        end
        m_sys_ready = sg || sz;
    endtask

    // Monitor: compares the write port against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_en", wr_en, e.en);
            check("wr_reg", wr_reg, e.rg);
            check("wr_data", wr_data, e.data);
        end
    end

    // Drives one cycle of inputs (called just after a rising edge).
    task automatic cycle(input logic a_wv, input logic [4:0] a_wr, input logic [31:0] a_wd,
                         input logic a_lv, input logic [31:0] a_la,
                         input logic a_sv, input logic [4:0] a_sr, input logic [31:0] a_sd);
        wb_valid = a_wv; wb_reg = a_wr; wb_data = a_wd;
        link_valid = a_lv; link_addr = a_la;
        sys_valid = a_sv; sys_reg = a_sr; sys_data = a_sd;
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic        wv, lv, sv;
        logic [4:0]  wr, sr;
        logic [31:0] wd, la, sd;
        int          wb_pct;

        rst = 1'b1;
        wb_valid = 0; wb_reg = 0; wb_data = 0;
        link_valid = 0; link_addr = 0;
        sys_valid = 0; sys_reg = 0; sys_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_reg", wr_reg, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_stall", stall_req, 0);
        check("rst_link_count", link_count, 0);
        check("rst_link_ready", link_ready, 1);
        rst = 1'b0;

        // 1. single wb write, visible for one cycle only
        cycle(1, 5'd8, 32'h0000_A5A5, 0, 0, 0, 0, 0);
        idle(2);

        // 2. link write, then fill FIFO while wb is busy, then drain in order
        cycle(0, 0, 0, 1, 32'h0040_0010, 0, 0, 0);
        idle(1);
        cycle(1, 5'd9,  32'h1111, 1, 32'h0040_0020, 0, 0, 0);
        cycle(1, 5'd10, 32'h2222, 1, 32'h0040_0030, 0, 0, 0);
        cycle(1, 5'd11, 32'h3333, 1, 32'h0040_0040, 0, 0, 0);
        idle(3);

        // 3. link and sys contend twice: link first, then sys first
        cycle(1, 5'd5, 32'h5, 1, 32'h0000_0100, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 5'd3, 32'hD003);
        cycle(0, 0, 0, 0, 0, 1, 5'd3, 32'hD003);
        cycle(1, 5'd5, 32'h6, 1, 32'h0000_0200, 1, 5'd4, 32'hD004);
        cycle(0, 0, 0, 0, 0, 1, 5'd4, 32'hD004);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // 4. sys starved by wb until stall_req, then served
        for (int k = 0; k < 6; k++) cycle(1, 5'd5, 32'h50 + k, 0, 0, 1, 5'd7, 32'hD007);
        cycle(0, 0, 0, 0, 0, 1, 5'd7, 32'hD007);
        idle(3);

        // 5. wb to $zero is dropped; sys to $zero is acked without a write
        cycle(1, 5'd0, 32'hDEAD, 0, 0, 1, 5'd2, 32'hD002);
        cycle(0, 0, 0, 0, 0, 1, 5'd0, 32'hBEEF);
        cycle(1, 5'd12, 32'hC, 0, 0, 1, 5'd0, 32'hBEEF);
        idle(2);

        // 6. reset with two queued link entries and a write in flight
        cycle(1, 5'd5, 32'h7, 1, 32'hAAAA_0000, 0, 0, 0);
        cycle(1, 5'd6, 32'h8, 1, 32'hBBBB_0000, 0, 0, 0);
        check("t6_pre_wr_en", wr_en, 1);
        check("t6_pre_count", link_count, 2);
        wb_valid = 0; link_valid = 0;
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_wr_en", wr_en, 0);
        check("t6_wr_reg", wr_reg, 0);
        check("t6_wr_data", wr_data, 0);
        check("t6_count", link_count, 0);
        check("t6_stall", stall_req, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // Randomized traffic, alternating light and heavy wb load
        sv = 0; sr = 0; sd = 0;
        for (int i = 0; i < 3000; i++) begin
            wb_pct = ((i / 400) % 2 == 1) ? 90 : 35;
            wv = ($urandom_range(0, 99) < wb_pct);
            wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wd = $urandom;
            lv = ($urandom_range(0, 99) < 30);
            la = $urandom;
            if (!sv || m_sys_ready) begin
                sv = ($urandom_range(0, 99) < 40);
                sr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                sd = $urandom;
            end
            cycle(wv, wr, wd, lv, la, sv, sr, sd);
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
